// File: rtl/xbus_pkg.sv
// Shared types and constants for the xbus master.
// Holds the FSM state encoding and the phase-timer width.
package xbus_pkg;

    localparam int TIMER_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    // A phase of n cycles is counted as n-1 down to 0.
    function automatic logic [TIMER_W-1:0] phase_load(input int unsigned cyc);
        return TIMER_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/xbus_timer.sv
// Loadable down-counter used to time the bus phases.
// Counts down to zero and stays there until reloaded.
module xbus_timer
    import xbus_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Load,
    input  logic [TIMER_W-1:0] LoadVal,
    output logic               Zero
);

    logic [TIMER_W-1:0] count;

    // Load on phase entry, otherwise decrement until zero.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (Load) begin
            count <= LoadVal;
        end else if (count != '0) begin
            count <= count - TIMER_W'(1);
        end
    end

    assign Zero = (count == '0);

endmodule

// File: rtl/xbus_master.sv
// Simple peripheral bus master: one host request becomes a
// SETUP / STROBE / HOLD bus cycle followed by a response pulse.
module xbus_master
    import xbus_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [3:0]  ReqAddr,
    input  logic [15:0] ReqData,
    output logic        RspValid,
    output logic [15:0] RspData,
    output logic [3:0]  Addr,
    output logic [15:0] DataWr,
    input  logic [15:0] DataRd,
    output logic        En,
    output logic        Rd,
    output logic        Wr
);

    state_t             state;
    state_t             state_n;
    logic               load;
    logic [TIMER_W-1:0] load_val;
    logic               zero;
    logic               accept;
    logic               is_wr;
    logic               ready_q;
    logic [15:0]        rd_cap;

    xbus_timer u_timer (
        .Clk     (Clk),
        .Reset   (Reset),
        .Load    (load),
        .LoadVal (load_val),
        .Zero    (zero)
    );

    // Ready stays low until the first edge after reset releases.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign ReqReady = ready_q && (state == IDLE);

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; each phase reloads the timer on entry.
    always_comb begin
        state_n  = state;
        load     = 1'b0;
        load_val = '0;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                if (ReqValid && ReqReady) begin
                    accept   = 1'b1;
                    state_n  = SETUP;
                    load     = 1'b1;
                    load_val = phase_load(SETUP_CYC);
                end
            end
            SETUP: begin
                if (zero) begin
                    state_n  = STROBE;
                    load     = 1'b1;
                    load_val = phase_load(STROBE_CYC);
                end
            end
            STROBE: begin
                if (zero) begin
                    state_n  = HOLD;
                    load     = 1'b1;
                    load_val = phase_load(HOLD_CYC);
                end
            end
            HOLD: begin
                if (zero) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Bus strobes/select registered from the next state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            En <= 1'b0;
            Rd <= 1'b0;
            Wr <= 1'b0;
        end else begin
            En <= (state_n != IDLE);
            Rd <= (state_n == STROBE) && !is_wr;
            Wr <= (state_n == STROBE) && is_wr;
        end
    end

    // Request capture: address, direction and write data.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Addr   <= '0;
            DataWr <= '0;
            is_wr  <= 1'b0;
        end else if (accept) begin
            Addr  <= ReqAddr;
            is_wr <= ReqWrite;
            if (ReqWrite) begin
                DataWr <= ReqData;
            end
        end
    end

    // Read data sampled on the edge ending the last strobe cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_cap <= '0;
        end else if (state == STROBE && zero && !is_wr) begin
            rd_cap <= DataRd;
        end
    end

    // Completion pulse and response data, held until the next one.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            RspValid <= 1'b0;
            RspData  <= '0;
        end else begin
            RspValid <= (state == HOLD) && zero;
            if (state == HOLD && zero) begin
                RspData <= is_wr ? 16'h0000 : rd_cap;
            end
        end
    end

endmodule

// File: tb/tb_xbus_master.sv
// Random-stimulus bench for xbus_master, two timing configurations
// checked every cycle against a cycle-offset reference model.
module tb_xbus_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    logic        req_valid [2];
    logic        req_write [2];
    logic [3:0]  req_addr  [2];
    logic [15:0] req_data  [2];
    logic [15:0] data_rd   [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic [15:0] rsp_data  [2];
    logic [3:0]  addr      [2];
    logic [15:0] data_wr   [2];
    logic        en        [2];
    logic        rd        [2];
    logic        wr        [2];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int S = (g == 0) ? 1 : 3;
        localparam int T = (g == 0) ? 2 : 1;
        localparam int H = (g == 0) ? 1 : 2;
        localparam int L = S + T + H;

        xbus_master #(
            .SETUP_CYC  (S),
            .STROBE_CYC (T),
            .HOLD_CYC   (H)
        ) dut (
            .Clk      (clk),
            .Reset    (rst),
            .ReqValid (req_valid[g]),
            .ReqReady (req_ready[g]),
            .ReqWrite (req_write[g]),
            .ReqAddr  (req_addr[g]),
            .ReqData  (req_data[g]),
            .RspValid (rsp_valid[g]),
            .RspData  (rsp_data[g]),
            .Addr     (addr[g]),
            .DataWr   (data_wr[g]),
            .DataRd   (data_rd[g]),
            .En       (en[g]),
            .Rd       (rd[g]),
            .Wr       (wr[g])
        );

        // k = cycles since acceptance (0 = idle); bus cycle spans k=1..L
        int          k      = 0;
        int          n_done = 0;
        bit          rdy_en = 0;
        bit          m_wop  = 0;
        bit          m_rspv = 0;
        logic [3:0]  m_addr = '0;
        logic [15:0] m_dw   = '0;
        logic [15:0] m_cap  = '0;
        logic [15:0] m_rsp  = '0;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                k      <= 0;
                rdy_en <= 0;
                m_wop  <= 0;
                m_rspv <= 0;
                m_addr <= '0;
                m_dw   <= '0;
                m_cap  <= '0;
                m_rsp  <= '0;
            end else begin
                rdy_en <= 1;
                m_rspv <= 0;
                if (k == 0) begin
                    if (rdy_en && req_valid[g]) begin
                        k      <= 1;
                        m_addr <= req_addr[g];
                        m_wop  <= req_write[g];
                        if (req_write[g]) m_dw <= req_data[g];
                    end
                end else begin
                    if (k == S + T && !m_wop) m_cap <= data_rd[g];
                    if (k == L) begin
                        k      <= 0;
                        m_rspv <= 1;
                        m_rsp  <= m_wop ? 16'h0000 : m_cap;
                        n_done <= n_done + 1;
                    end else begin
                        k <= k + 1;
                    end
                end
            end
        end

        always @(negedge clk) begin
            bit strobe;
            strobe = (k >= S + 1) && (k <= S + T);
            chk($sformatf("d%0d ready", g), 32'(req_ready[g]),
                32'(rdy_en && k == 0));
            chk($sformatf("d%0d en", g), 32'(en[g]), 32'(k >= 1));
            chk($sformatf("d%0d rd", g), 32'(rd[g]), 32'(strobe && !m_wop));
            chk($sformatf("d%0d wr", g), 32'(wr[g]), 32'(strobe && m_wop));
            chk($sformatf("d%0d addr", g), 32'(addr[g]), 32'(m_addr));
            chk($sformatf("d%0d data_wr", g), 32'(data_wr[g]), 32'(m_dw));
            chk($sformatf("d%0d rsp_valid", g), 32'(rsp_valid[g]), 32'(m_rspv));
            chk($sformatf("d%0d rsp_data", g), 32'(rsp_data[g]), 32'(m_rsp));
        end
    end

    task automatic randomize_inputs();
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = ($urandom_range(0, 2) != 0);
            req_write[d] = $urandom_range(0, 1) == 1;
            req_addr[d]  = 4'($urandom);
            req_data[d]  = 16'($urandom);
            data_rd[d]   = 16'($urandom);
        end
    endtask

    task automatic run_random(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            randomize_inputs();
        end
    endtask

    initial begin
        bit seen;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_write[d] = 1'b0;
            req_addr[d]  = '0;
            req_data[d]  = '0;
            data_rd[d]   = '0;
        end
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Directed first write on the default-timing instance.
        @(posedge clk);
        #1;
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 4'd3;
        req_data[0]  = 16'hA55A;
        run_random(600);

        // Reset in the middle of a write strobe.
        @(posedge clk);
        #1;
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (wr[0]) seen = 1;
        end
        chk("d0 strobe_seen", 32'(seen), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("d0 wr_async", 32'(wr[0]), 32'd0);
        chk("d0 en_async", 32'(en[0]), 32'd0);
        chk("d0 rsp_async", 32'(rsp_valid[0]), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        run_random(300);

        @(negedge clk);
        chk("d0 txns", 32'(g_dut[0].n_done >= 20), 32'd1);
        chk("d1 txns", 32'(g_dut[1].n_done >= 20), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
